// File: rtl/uart_cmd_slv.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_cmd_slv
// Purpose  : Host UART command link slave. Assembles 3-byte 8N1 commands from
//            RX into a 24-bit word with cmd_rdy, and serialises 1-byte
//            responses onto TX. Full duplex, RX and TX independent.
// Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_slv #(
  parameter logic [15:0] BAUD_DIV = 16'd2604,
  parameter logic [7:0]  GAP_BITS = 8'd20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [23:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  output logic        frm_err,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent,
  output logic        tx_busy
);

  localparam logic [15:0] C_BAUD_M1 = BAUD_DIV - 16'd1;
  localparam logic [15:0] C_HALF_M1 = (BAUD_DIV >> 1) - 16'd1;
  localparam logic [23:0] C_GAP_M1  = ({16'd0, GAP_BITS} * {8'd0, BAUD_DIV}) - 24'd1;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic       {TX_IDLE, TX_RUN} tx_state_e;

  // ---------------- receive side ----------------
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] cmd_q, cmd_d;
  logic        cmd_rdy_q, cmd_rdy_d;
  logic        frm_err_q, frm_err_d;
  logic [23:0] gap_q, gap_d;

  // ---------------- transmit side ----------------
  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]  tx_bit_q, tx_bit_d;
  logic [8:0]  tx_sh_q, tx_sh_d;
  logic        tx_q, tx_d;
  logic        resp_sent_q, resp_sent_d;

  // Synchronise RX into the clock domain and keep one more stage for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= RX;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  // Receive state and command assembly registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= 16'd0;
      rx_bit_q   <= 3'd0;
      rx_sh_q    <= 8'd0;
      byte_cnt_q <= 2'd0;
      cmd_q      <= 24'd0;
      cmd_rdy_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      gap_q      <= 24'd0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      byte_cnt_q <= byte_cnt_d;
      cmd_q      <= cmd_d;
      cmd_rdy_q  <= cmd_rdy_d;
      frm_err_q  <= frm_err_d;
      gap_q      <= gap_d;
    end
  end

  // Receive next-state: bit timing, byte storage, cmd_rdy and partial-command timeout
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    byte_cnt_d = byte_cnt_q;
    cmd_d      = cmd_q;
    cmd_rdy_d  = cmd_rdy_q;
    frm_err_d  = 1'b0;
    gap_d      = 24'd0;

    // A clear is overridden below when the third byte lands in the same cycle
    if (clr_cmd_rdy) cmd_rdy_d = 1'b0;

    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = 16'd0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == C_HALF_M1) begin
          rx_cnt_d   = 16'd0;
          rx_bit_d   = 3'd0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == C_BAUD_M1) begin
          rx_cnt_d = 16'd0;
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == C_BAUD_M1) begin
          rx_cnt_d   = 16'd0;
          rx_state_d = RX_IDLE;
          if (rx_s2_q) begin
            case (byte_cnt_q)
              2'd0: begin
                cmd_d[23:16] = rx_sh_q;
                cmd_rdy_d    = 1'b0;
                byte_cnt_d   = 2'd1;
              end
              2'd1: begin
                cmd_d[15:8] = rx_sh_q;
                byte_cnt_d  = 2'd2;
              end
              default: begin
                cmd_d[7:0] = rx_sh_q;
                cmd_rdy_d  = 1'b1;
                byte_cnt_d = 2'd0;
              end
            endcase
          end else begin
            frm_err_d  = 1'b1;
            byte_cnt_d = 2'd0;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase

    // Idle line with a partial command pending: drop it after the gap time
    if ((rx_state_q == RX_IDLE) && rx_s2_q && (byte_cnt_q != 2'd0)) begin
      if (gap_q == C_GAP_M1) byte_cnt_d = 2'd0;
      else                   gap_d      = gap_q + 24'd1;
    end
  end

  // Transmit state and shift registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= 16'd0;
      tx_bit_q    <= 4'd0;
      tx_sh_q     <= 9'h1FF;
      tx_q        <= 1'b1;
      resp_sent_q <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_sh_q     <= tx_sh_d;
      tx_q        <= tx_d;
      resp_sent_q <= resp_sent_d;
    end
  end

  // Transmit next-state: start bit on acceptance, then data LSB first and the stop bit
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bit_d    = tx_bit_q;
    tx_sh_d     = tx_sh_q;
    tx_d        = tx_q;
    resp_sent_d = resp_sent_q;

    case (tx_state_q)
      TX_IDLE: begin
        if (send_resp) begin
          tx_state_d  = TX_RUN;
          tx_sh_d     = {1'b1, resp};
          tx_d        = 1'b0;
          tx_cnt_d    = 16'd0;
          tx_bit_d    = 4'd0;
          resp_sent_d = 1'b0;
        end
      end
      TX_RUN: begin
        if (tx_cnt_q == C_BAUD_M1) begin
          tx_cnt_d = 16'd0;
          if (tx_bit_q == 4'd9) begin
            tx_state_d  = TX_IDLE;
            tx_d        = 1'b1;
            resp_sent_d = 1'b1;
          end else begin
            tx_d     = tx_sh_q[0];
            tx_sh_d  = {1'b1, tx_sh_q[8:1]};
            tx_bit_d = tx_bit_q + 4'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  assign TX        = tx_q;
  assign tx_busy   = (tx_state_q == TX_RUN);
  assign resp_sent = resp_sent_q;
  assign cmd       = cmd_q;
  assign cmd_rdy   = cmd_rdy_q;
  assign frm_err   = frm_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_slv.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_cmd_slv
// Purpose  : Randomised and directed bench for uart_cmd_slv with a
//            cycle-accurate behavioural model of the link.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_slv;

  localparam int BD       = 16;
  localparam int FRAME    = 10 * BD;
  localparam int STOP_LAT = 155;   // RX driven low after edge n -> stop sampled at edge n+155
  localparam int GAP_CYC  = 4 * BD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic        TX;
  logic [23:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic        frm_err;
  logic [7:0]  resp = 8'h00;
  logic        send_resp = 1'b0;
  logic        resp_sent;
  logic        tx_busy;

  uart_cmd_slv #(.BAUD_DIV(16'd16), .GAP_BITS(8'd4)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .frm_err(frm_err), .resp(resp),
    .send_resp(send_resp), .resp_sent(resp_sent), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  int ferr_seen = 0;

  // ---------------- behavioural model ----------------
  typedef struct {
    int         n;
    int         s;
    bit         ok;
    logic [7:0] b;
  } rx_ev_t;

  rx_ev_t      evq[$];
  rx_ev_t      cur_ev;
  int          cyc = 0;
  logic [23:0] m_cmd;
  bit          m_rdy;
  int          m_bcnt;
  int          m_last_s;
  int          m_ferr;
  int          t_start;
  logic [7:0]  t_byte;

  function automatic void model_reset();
    evq.delete();
    m_cmd    = 24'h0;
    m_rdy    = 1'b0;
    m_bcnt   = 0;
    m_last_s = -100000;
    m_ferr   = -1;
    t_start  = -1;
    t_byte   = 8'h00;
  endfunction

  function automatic logic exp_tx(input int n);
    int i;
    if (t_start < 0 || n >= t_start + FRAME) return 1'b1;
    i = (n - t_start) / BD;
    if (i == 0) return 1'b0;
    if (i == 9) return 1'b1;
    return t_byte[i-1];
  endfunction

  function automatic logic exp_busy(input int n);
    return (t_start >= 0) && (n >= t_start) && (n < t_start + FRAME);
  endfunction

  function automatic logic exp_sent(input int n);
    return (t_start >= 0) && (n >= t_start + FRAME);
  endfunction

  // Model update at every rising edge, using inputs as the DUT samples them
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) model_reset();
      else begin
        if (clr_cmd_rdy) m_rdy = 1'b0;
        if (send_resp && !exp_busy(cyc - 1)) begin
          t_start = cyc;
          t_byte  = resp;
        end
        if (evq.size() > 0 && evq[0].s == cyc) begin
          cur_ev = evq.pop_front();
          if (!cur_ev.ok) begin
            m_ferr = cyc;
            m_bcnt = 0;
          end else begin
            if (m_bcnt != 0 && (cur_ev.n - m_last_s) > GAP_CYC) m_bcnt = 0;
            case (m_bcnt)
              0: begin m_cmd[23:16] = cur_ev.b; m_rdy = 1'b0; m_bcnt = 1; end
              1: begin m_cmd[15:8]  = cur_ev.b; m_bcnt = 2; end
              default: begin m_cmd[7:0] = cur_ev.b; m_rdy = 1'b1; m_bcnt = 0; end
            endcase
            m_last_s = cyc;
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge rst_n);
    model_reset();
  end

  // Per-cycle comparison of every output against the model
  logic [28:0] exp_v, act_v;
  initial forever begin
    @(negedge clk);
    if (rst_n && chk_en) begin
      exp_v = {m_cmd, m_rdy, (m_ferr == cyc), exp_tx(cyc), exp_busy(cyc), exp_sent(cyc)};
      act_v = {cmd, cmd_rdy, frm_err, TX, tx_busy, resp_sent};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_bad++;
        $display("FAIL cyc=%0d outputs{cmd,rdy,ferr,tx,busy,sent}: got %h want %h", cyc, act_v, exp_v);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && frm_err === 1'b1) ferr_seen++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run exceeded time limit, got timeout want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    logic [9:0] fr;
    rx_ev_t     e;
    fr   = {stop_ok, b, 1'b0};
    e.n  = cyc;
    e.s  = cyc + STOP_LAT;
    e.ok = stop_ok;
    e.b  = b;
    evq.push_back(e);
    for (int i = 0; i < 10; i++) begin
      RX = fr[i];
      tick(BD);
    end
    RX = 1'b1;
    if (!stop_ok) tick(BD);
  endtask

  task automatic pulse_send(input logic [7:0] b);
    resp      = b;
    send_resp = 1'b1;
    tick(1);
    send_resp = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_cmd_rdy = 1'b1;
    tick(1);
    clr_cmd_rdy = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  int         k;
  int         f0;
  logic [9:0] cap;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_vals", 32'({TX, cmd, cmd_rdy, frm_err, resp_sent, tx_busy}), 32'h1000_0000);
    @(posedge clk);
    #2;
    rst_n  = 1'b1;
    chk_en = 1'b1;
    tick(4);

    // 1: basic command assembly and clear
    send_frame(8'h02, 1'b1);
    send_frame(8'h0D, 1'b1);
    send_frame(8'h01, 1'b1);
    check("t1_cmd", 32'(cmd), 32'h0002_0D01);
    check("t1_model_cmd", 32'(m_cmd), 32'h0002_0D01);
    check("t1_rdy", 32'(cmd_rdy), 32'd1);
    tick(5);
    check("t1_rdy_held", 32'(cmd_rdy), 32'd1);
    pulse_clr();
    check("t1_rdy_cleared", 32'(cmd_rdy), 32'd0);

    // 2: response frame shape, ignored mid-frame strobe, completion timing
    k = cyc + 1;
    pulse_send(8'hA5);
    for (int i = 0; i < 10; i++) begin
      while (cyc < k + 8 + BD * i) tick(1);
      cap[i] = TX;
      if (i == 4) pulse_send(8'h00);
    end
    check("t2_frame", 32'(cap), 32'h0000_034A);
    while (cyc < k + FRAME - 1) tick(1);
    check("t2_busy_last", 32'({tx_busy, resp_sent}), 32'h2);
    tick(1);
    check("t2_done", 32'({tx_busy, resp_sent, TX}), 32'h3);

    // 3: framing error then a good command
    f0 = ferr_seen;
    send_frame(8'h03, 1'b0);
    check("t3_ferr_pulses", 32'(ferr_seen - f0), 32'd1);
    send_frame(8'h03, 1'b1);
    send_frame(8'h00, 1'b1);
    send_frame(8'h80, 1'b1);
    check("t3_cmd", 32'({cmd_rdy, cmd}), 32'h0103_0080);

    // 4: partial command dropped by the gap timer
    send_frame(8'h04, 1'b1);
    tick(80 * BD);
    send_frame(8'h05, 1'b1);
    send_frame(8'h00, 1'b1);
    check("t4_rdy_not_yet", 32'(cmd_rdy), 32'd0);
    send_frame(8'h03, 1'b1);
    check("t4_cmd", 32'({cmd_rdy, cmd}), 32'h0105_0003);

    // 5: glitch rejection and full duplex
    pulse_send(8'hEE);
    send_frame(8'h07, 1'b1);
    tick(BD);
    RX = 1'b0;
    tick(4);
    RX = 1'b1;
    tick(BD);
    send_frame(8'h00, 1'b1);
    send_frame(8'h00, 1'b1);
    check("t5_cmd", 32'({cmd_rdy, cmd}), 32'h0107_0000);
    check("t5_model_resp", 32'(t_byte), 32'h0000_00EE);
    check("t5_sent", 32'({tx_busy, resp_sent}), 32'h1);

    // 7: clear on the same cycle as the third byte lands -> set wins
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    fork
      send_frame(8'h33, 1'b1);
      begin
        tick(STOP_LAT - 1);
        pulse_clr();
      end
    join
    check("t7_set_wins", 32'({cmd_rdy, cmd}), 32'h0111_2233);
    pulse_clr();
    check("t7_clr", 32'(cmd_rdy), 32'd0);

    // 6: reset in the middle of an RX and a TX frame
    pulse_send(8'h3C);
    RX = 1'b0;
    tick(50);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_reset_vals", 32'({TX, cmd, cmd_rdy, frm_err, resp_sent, tx_busy}), 32'h1000_0000);
    tick(3);
    RX = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(BD);
    check("t6_after_release", 32'({TX, cmd, cmd_rdy, frm_err, resp_sent, tx_busy}), 32'h1000_0000);
    send_frame(8'h0A, 1'b1);
    send_frame(8'h0B, 1'b1);
    send_frame(8'h0C, 1'b1);
    check("t6_cmd", 32'({cmd_rdy, cmd}), 32'h010A_0B0C);

    // Randomised traffic against the model
    for (int c = 0; c < 14; c++) begin
      for (int j = 0; j < 3; j++) begin
        if ($urandom_range(0, 2) == 0) pulse_send(8'($urandom_range(0, 255)));
        if ($urandom_range(0, 3) == 0) pulse_clr();
        if (j > 0 && $urandom_range(0, 5) == 0) tick(int'($urandom_range(96, 160)));
        else                                     tick(int'($urandom_range(0, 30)));
        send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 7) != 0));
      end
    end
    tick(FRAME + 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
